// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Arbitrates three message sources onto a byte-wide TX FIFO.
//               A winning requester's message (up to 8 bytes, left-aligned)
//               is latched at grant time and streamed one byte per cycle
//               while the FIFO is not full. Round-robin or fixed priority.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1   rising-edge clock
//   rst        in   1   asynchronous active-low reset
//   req        in   3   per-requester request, held until its done pulse
//   msg0..2    in  64   payload, first byte sent is [63:56]
//   len0..2    in   4   byte count, legal 1..MAX_LEN
//   fifo_full  in   1   TX FIFO full flag
//   fifo_din   out  8   byte written to the FIFO (8'h00 when not writing)
//   fifo_wr_en out  1   FIFO write strobe
//   gnt        out  3   one-hot grant pulse
//   done       out  3   one-hot completion pulse
//   err_len    out  1   illegal-length pulse (coincides with done)
//   busy       out  1   high while not IDLE
// ============================================================================
module uart_tx_arbiter #(
  parameter int unsigned PRIO_MODE = 0,
  parameter int unsigned MAX_LEN   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [63:0] msg0,
  input  logic [63:0] msg1,
  input  logic [63:0] msg2,
  input  logic [3:0]  len0,
  input  logic [3:0]  len1,
  input  logic [3:0]  len2,
  input  logic        fifo_full,
  output logic [7:0]  fifo_din,
  output logic        fifo_wr_en,
  output logic [2:0]  gnt,
  output logic [2:0]  done,
  output logic        err_len,
  output logic        busy
);

  localparam logic [3:0] c_max_len = 4'(MAX_LEN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic [1:0]  r_ptr;
  logic [1:0]  r_owner;
  logic [63:0] r_msg;
  logic [3:0]  r_len;
  logic        r_err_pend;
  logic [2:0]  r_gnt;
  logic [2:0]  r_done;
  logic        r_err_len;
  logic        r_wr_en;
  logic [7:0]  r_din;

  logic        w_win_vld;
  logic [1:0]  w_win_idx;
  logic [2:0]  w_win_oh;
  logic [2:0]  w_owner_oh;
  logic [63:0] w_msg_sel;
  logic [3:0]  w_len_sel;
  logic        w_len_ok;
  logic [63:0] w_msg_shift;
  logic [7:0]  w_byte;
  logic        w_last;

  // Winner selection. Round-robin starts searching just above the last
  // served index, so a reset pointer of 2 makes index 0 the first winner.
  always_comb begin
    w_win_vld = |req;
    w_win_idx = 2'd0;
    if (PRIO_MODE == 1) begin
      if (req[0])      w_win_idx = 2'd0;
      else if (req[1]) w_win_idx = 2'd1;
      else if (req[2]) w_win_idx = 2'd2;
    end else begin
      case (r_ptr)
        2'd0: begin
          if (req[1])      w_win_idx = 2'd1;
          else if (req[2]) w_win_idx = 2'd2;
          else if (req[0]) w_win_idx = 2'd0;
        end
        2'd1: begin
          if (req[2])      w_win_idx = 2'd2;
          else if (req[0]) w_win_idx = 2'd0;
          else if (req[1]) w_win_idx = 2'd1;
        end
        default: begin
          if (req[0])      w_win_idx = 2'd0;
          else if (req[1]) w_win_idx = 2'd1;
          else if (req[2]) w_win_idx = 2'd2;
        end
      endcase
    end
  end

  always_comb begin
    case (w_win_idx)
      2'd0:    begin w_msg_sel = msg0; w_len_sel = len0; end
      2'd1:    begin w_msg_sel = msg1; w_len_sel = len1; end
      default: begin w_msg_sel = msg2; w_len_sel = len2; end
    endcase
  end

  assign w_win_oh    = 3'b001 << w_win_idx;
  assign w_owner_oh  = 3'b001 << r_owner;
  assign w_len_ok    = (w_len_sel != 4'd0) && (w_len_sel <= c_max_len);
  // Shift the latched message so the current byte lands in the top lane.
  assign w_msg_shift = r_msg << {r_cnt, 3'b000};
  assign w_byte      = w_msg_shift[63:56];
  assign w_last      = ({1'b0, r_cnt} == (r_len - 4'd1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 3'd0;
      r_ptr      <= 2'd2;
      r_owner    <= 2'd0;
      r_msg      <= 64'd0;
      r_len      <= 4'd0;
      r_err_pend <= 1'b0;
      r_gnt      <= 3'd0;
      r_done     <= 3'd0;
      r_err_len  <= 1'b0;
      r_wr_en    <= 1'b0;
      r_din      <= 8'h00;
    end else begin
      // Pulse outputs default low every cycle.
      r_gnt     <= 3'd0;
      r_done    <= 3'd0;
      r_err_len <= 1'b0;
      r_wr_en   <= 1'b0;
      r_din     <= 8'h00;
      case (r_state)
        ST_IDLE: begin
          if (r_err_pend) begin
            // Finish the rejected grant; arbitration is held off this cycle
            // so the still-asserted request is not granted a second time.
            r_err_pend <= 1'b0;
            r_err_len  <= 1'b1;
            r_done     <= w_owner_oh;
            r_ptr      <= r_owner;
          end else if (w_win_vld) begin
            r_owner <= w_win_idx;
            r_gnt   <= w_win_oh;
            r_cnt   <= 3'd0;
            r_msg   <= w_msg_sel;
            r_len   <= w_len_sel;
            if (w_len_ok) r_state    <= ST_SEND;
            else          r_err_pend <= 1'b1;
          end
        end
        ST_SEND: begin
          if (!fifo_full) begin
            r_wr_en <= 1'b1;
            r_din   <= w_byte;
            r_cnt   <= r_cnt + 3'd1;
            if (w_last) r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done  <= w_owner_oh;
          r_ptr   <= r_owner;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign fifo_din   = r_din;
  assign fifo_wr_en = r_wr_en;
  assign gnt        = r_gnt;
  assign done       = r_done;
  assign err_len    = r_err_len;
  assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench for uart_tx_arbiter. One round-robin and
//               one fixed-priority instance share stimulus; each scenario
//               observes one of them and compares against a message-level
//               reference model (service order, byte stream, error count).
// Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int c_bound = 400;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [63:0] msg0, msg1, msg2;
  logic [3:0]  len0, len1, len2;
  logic        fifo_full;

  logic [7:0]  din_rr, din_fp;
  logic        wr_rr, wr_fp, err_rr, err_fp, busy_rr, busy_fp;
  logic [2:0]  gnt_rr, gnt_fp, done_rr, done_fp;

  bit          fp_sel;
  logic [7:0]  o_din;
  logic        o_wr, o_err, o_busy;
  logic [2:0]  o_gnt, o_done;

  assign o_din  = fp_sel ? din_fp  : din_rr;
  assign o_wr   = fp_sel ? wr_fp   : wr_rr;
  assign o_err  = fp_sel ? err_fp  : err_rr;
  assign o_busy = fp_sel ? busy_fp : busy_rr;
  assign o_gnt  = fp_sel ? gnt_fp  : gnt_rr;
  assign o_done = fp_sel ? done_fp : done_rr;

  uart_tx_arbiter #(.PRIO_MODE(0), .MAX_LEN(8)) u_rr (
    .clk(clk), .rst(rst), .req(req),
    .msg0(msg0), .msg1(msg1), .msg2(msg2),
    .len0(len0), .len1(len1), .len2(len2),
    .fifo_full(fifo_full), .fifo_din(din_rr), .fifo_wr_en(wr_rr),
    .gnt(gnt_rr), .done(done_rr), .err_len(err_rr), .busy(busy_rr)
  );

  uart_tx_arbiter #(.PRIO_MODE(1), .MAX_LEN(8)) u_fp (
    .clk(clk), .rst(rst), .req(req),
    .msg0(msg0), .msg1(msg1), .msg2(msg2),
    .len0(len0), .len1(len1), .len2(len2),
    .fifo_full(fifo_full), .fifo_din(din_fp), .fifo_wr_en(wr_fp),
    .gnt(gnt_fp), .done(done_fp), .err_len(err_fp), .busy(busy_fp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Scenario plan: per requester, the messages it will send in order.
  logic [63:0] plan_msg [3][4];
  logic [3:0]  plan_len [3][4];
  int          plan_n   [3];
  int          full_mode;
  bit          early_drop;

  // Observations of one scenario.
  int          q_gnt[$], q_done[$], g_cyc[$], w_cyc[$], d_cyc[$];
  logic [7:0]  q_byte[$];
  int          n_err, full_viol, proto_viol;
  bit          timed_out;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int oh2i(input logic [2:0] v);
    if (v[0]) return 0;
    if (v[1]) return 1;
    return 2;
  endfunction

  task automatic set_src(input int i, input logic [63:0] m, input logic [3:0] l);
    case (i)
      0:       begin msg0 = m; len0 = l; end
      1:       begin msg1 = m; len1 = l; end
      default: begin msg2 = m; len2 = l; end
    endcase
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 3; i++) begin
      plan_n[i] = 0;
      for (int k = 0; k < 4; k++) begin
        plan_msg[i][k] = 64'd0;
        plan_len[i][k] = 4'd1;
      end
    end
    full_mode  = 0;
    early_drop = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; req = 3'b000; fifo_full = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_rr", {gnt_rr, done_rr, err_rr, wr_rr, din_rr, busy_rr}, 64'd0);
    chk("reset_fp", {gnt_fp, done_fp, err_fp, wr_fp, din_fp, busy_fp}, 64'd0);
    rst = 1'b1;
  endtask

  // Drives the plan and records what the observed instance does. A requester
  // keeps req high while it has messages left; its req drops at its last
  // done, or right after its last grant when early_drop is set.
  task automatic run_scn();
    int gc [3];
    int total, ndone, cyc, bp_left, w;
    q_gnt.delete(); q_done.delete(); g_cyc.delete(); w_cyc.delete();
    d_cyc.delete(); q_byte.delete();
    n_err = 0; full_viol = 0; proto_viol = 0;
    total = 0; ndone = 0; cyc = 0; bp_left = 0;
    for (int i = 0; i < 3; i++) begin
      gc[i] = 0;
      total += plan_n[i];
      if (plan_n[i] > 0) set_src(i, plan_msg[i][0], plan_len[i][0]);
      else               set_src(i, {$urandom, $urandom}, 4'($urandom));
      req[i] = (plan_n[i] > 0);
    end
    fifo_full = 1'b0;
    while (ndone < total && cyc < c_bound) begin
      @(negedge clk);
      cyc++;
      if (o_wr) begin
        q_byte.push_back(o_din);
        w_cyc.push_back(cyc);
        if (fifo_full) full_viol++;
        if (full_mode == 2 && q_byte.size() == 2) bp_left = 3;
      end
      if (o_gnt != 3'b000) begin
        w = oh2i(o_gnt);
        if (!$onehot(o_gnt)) proto_viol++;
        q_gnt.push_back(w);
        g_cyc.push_back(cyc);
        gc[w]++;
        if (gc[w] < plan_n[w]) set_src(w, plan_msg[w][gc[w]], plan_len[w][gc[w]]);
        else begin
          set_src(w, {$urandom, $urandom}, 4'($urandom));
          if (early_drop) req[w] = 1'b0;
        end
      end
      if (o_done != 3'b000) begin
        w = oh2i(o_done);
        if (!$onehot(o_done)) proto_viol++;
        q_done.push_back(w);
        d_cyc.push_back(cyc);
        ndone++;
        if (o_err) n_err++;
        if (gc[w] >= plan_n[w]) req[w] = 1'b0;
      end else if (o_err) begin
        proto_viol++;
      end
      case (full_mode)
        1: fifo_full = ($urandom_range(0, 3) == 0);
        2: begin
          fifo_full = (bp_left > 0);
          if (bp_left > 0) bp_left--;
        end
        default: fifo_full = 1'b0;
      endcase
    end
    timed_out = (ndone < total);
    chk("busy_after_last_done", {63'd0, o_busy}, 64'd0);
    req = 3'b000;
    fifo_full = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (o_gnt != 3'b000 || o_done != 3'b000 || o_err) proto_viol++;
      if (o_wr) q_byte.push_back(o_din);
    end
  endtask

  // Reference: serve requesters one message at a time in arbitration order,
  // pointer starting at 2 after reset; legal messages emit their top len
  // bytes, illegal lengths emit nothing and count one error.
  task automatic check_scn(input string nm);
    int          rem [3];
    int          k [3];
    int          eg[$];
    logic [7:0]  eb[$];
    int          ptr, win, eerr, c;
    logic [63:0] m, t;
    logic [3:0]  l;
    ptr = 2; eerr = 0;
    for (int i = 0; i < 3; i++) begin rem[i] = plan_n[i]; k[i] = 0; end
    while (rem[0] + rem[1] + rem[2] > 0) begin
      win = -1;
      if (fp_sel) begin
        for (int i = 0; i < 3; i++) if (win < 0 && rem[i] > 0) win = i;
      end else begin
        for (int s = 1; s <= 3; s++) begin
          c = (ptr + s) % 3;
          if (win < 0 && rem[c] > 0) win = c;
        end
      end
      eg.push_back(win);
      m = plan_msg[win][k[win]];
      l = plan_len[win][k[win]];
      if (l >= 4'd1 && l <= 4'd8) begin
        for (int b = 0; b < int'(l); b++) begin
          t = m << (8 * b);
          eb.push_back(t[63:56]);
        end
      end else begin
        eerr++;
      end
      rem[win]--; k[win]++; ptr = win;
    end
    chk({nm, "/timeout"}, {63'd0, timed_out}, 64'd0);
    chk({nm, "/n_gnt"}, 64'(q_gnt.size()), 64'(eg.size()));
    chk({nm, "/n_done"}, 64'(q_done.size()), 64'(eg.size()));
    for (int j = 0; j < eg.size(); j++) begin
      if (j < q_gnt.size())  chk($sformatf("%s/gnt%0d", nm, j), 64'(q_gnt[j]), 64'(eg[j]));
      if (j < q_done.size()) chk($sformatf("%s/done%0d", nm, j), 64'(q_done[j]), 64'(eg[j]));
    end
    chk({nm, "/n_bytes"}, 64'(q_byte.size()), 64'(eb.size()));
    for (int j = 0; j < eb.size(); j++)
      if (j < q_byte.size()) chk($sformatf("%s/byte%0d", nm, j), 64'(q_byte[j]), 64'(eb[j]));
    chk({nm, "/n_err"}, 64'(n_err), 64'(eerr));
    chk({nm, "/wr_while_full"}, 64'(full_viol), 64'd0);
    chk({nm, "/pulse_protocol"}, 64'(proto_viol), 64'd0);
  endtask

  initial begin
    int ord [4];
    int nw, cyc, bad;
    rst = 1'b0; req = 3'b000; fifo_full = 1'b0; fp_sel = 1'b0;
    msg0 = '0; msg1 = '0; msg2 = '0; len0 = '0; len1 = '0; len2 = '0;

    // Single 7-byte message with exact timing.
    clear_plan(); do_reset(); fp_sel = 1'b0;
    plan_n[0] = 1; plan_msg[0][0] = 64'h4552524F52210A00; plan_len[0][0] = 4'd7;
    run_scn(); check_scn("single");
    if (g_cyc.size() > 0) chk("single/first_gnt_cycle", 64'(g_cyc[0]), 64'd1);
    chk("single/n_wcyc", 64'(w_cyc.size()), 64'd7);
    for (int j = 0; j < w_cyc.size() && j < 7; j++)
      chk($sformatf("single/wcyc%0d", j), 64'(w_cyc[j]), 64'(2 + j));
    if (d_cyc.size() > 0) chk("single/done_cycle", 64'(d_cyc[0]), 64'd9);

    // Round-robin contention, requester 0 re-requests after its done.
    clear_plan(); do_reset(); fp_sel = 1'b0;
    plan_n[0] = 2; plan_n[1] = 1; plan_n[2] = 1;
    plan_msg[0][0] = 64'hA100_0000_0000_0000; plan_msg[0][1] = 64'hA200_0000_0000_0000;
    plan_msg[1][0] = 64'hB100_0000_0000_0000; plan_msg[2][0] = 64'hC100_0000_0000_0000;
    run_scn(); check_scn("rr_contend");
    ord = '{0, 1, 2, 0};
    for (int j = 0; j < 4 && j < q_gnt.size(); j++)
      chk($sformatf("rr_contend/order%0d", j), 64'(q_gnt[j]), 64'(ord[j]));

    // Fixed priority: 1 before 2, then 0 wins every arbitration.
    clear_plan(); do_reset(); fp_sel = 1'b1;
    plan_n[1] = 1; plan_n[2] = 1;
    plan_msg[1][0] = 64'h1122_0000_0000_0000; plan_len[1][0] = 4'd2;
    plan_msg[2][0] = 64'h3344_5500_0000_0000; plan_len[2][0] = 4'd3;
    run_scn(); check_scn("fp_110");
    clear_plan(); do_reset(); fp_sel = 1'b1;
    plan_n[0] = 3; plan_n[1] = 1; plan_n[2] = 1;
    for (int k = 0; k < 3; k++) plan_msg[0][k] = {8'(8'hD0 + k), 56'd0};
    plan_msg[1][0] = 64'hE100_0000_0000_0000; plan_msg[2][0] = 64'hF100_0000_0000_0000;
    run_scn(); check_scn("fp_111");
    for (int j = 0; j < 3 && j < q_gnt.size(); j++)
      chk($sformatf("fp_111/zero_wins%0d", j), 64'(q_gnt[j]), 64'd0);

    // Backpressure: FIFO full for 3 cycles after the second byte.
    clear_plan(); do_reset(); fp_sel = 1'b0; full_mode = 2;
    plan_n[1] = 1; plan_msg[1][0] = 64'h1357_9BDF_0000_0000; plan_len[1][0] = 4'd4;
    run_scn(); check_scn("backpressure");
    if (w_cyc.size() >= 3) chk("backpressure/gap", 64'(w_cyc[2] - w_cyc[1]), 64'd4);

    // Illegal lengths 0 and 9.
    clear_plan(); do_reset(); fp_sel = 1'b0;
    plan_n[1] = 1; plan_n[2] = 1;
    plan_msg[1][0] = 64'hDEAD_BEEF_0000_0000; plan_len[1][0] = 4'd0;
    plan_msg[2][0] = 64'hCAFE_F00D_0000_0000; plan_len[2][0] = 4'd9;
    run_scn(); check_scn("bad_len");
    chk("bad_len/errs", 64'(n_err), 64'd2);

    // Reset after the 3rd byte of an 8-byte message.
    clear_plan(); do_reset(); fp_sel = 1'b0;
    req = 3'b100; msg2 = 64'h0102_0304_0506_0708; len2 = 4'd8;
    nw = 0; cyc = 0;
    while (nw < 3 && cyc < 50) begin
      @(negedge clk); cyc++;
      if (wr_rr) nw++;
    end
    chk("abort/third_byte_seen", 64'(nw), 64'd3);
    #2 rst = 1'b0;
    #1 chk("abort/async_reset", {gnt_rr, done_rr, err_rr, wr_rr, din_rr, busy_rr}, 64'd0);
    @(negedge clk);
    req = 3'b000;
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_rr != 3'b000 || wr_rr || gnt_rr != 3'b000) bad++;
    end
    chk("abort/quiet_after_release", 64'(bad), 64'd0);
    plan_n[0] = 1; plan_msg[0][0] = 64'h7766_5500_0000_0000; plan_len[0][0] = 4'd3;
    run_scn(); check_scn("abort/next_msg");

    // Randomized scenarios with random backpressure and source changes.
    for (int s = 0; s < 8; s++) begin
      clear_plan(); do_reset();
      fp_sel = 1'($urandom);
      full_mode = 1;
      early_drop = 1'($urandom);
      for (int i = 0; i < 3; i++) begin
        plan_n[i] = int'($urandom_range(0, 2));
        for (int k = 0; k < 4; k++) begin
          plan_msg[i][k] = {$urandom, $urandom};
          plan_len[i][k] = 4'($urandom_range(1, 8));
        end
      end
      if (plan_n[0] + plan_n[1] + plan_n[2] == 0) plan_n[2] = 1;
      run_scn(); check_scn($sformatf("rand%0d", s));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter PRIO_MODE, default 0; 0 = round-robin arbitration, 1 = fixed priority (index 0 highest).
REQ-002 Parameter MAX_LEN, default 8; maximum message length in bytes, fixed at 8 for this release.
REQ-003 clk  input  1  single clock; all logic is on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req  input  3  per-requester request; requester holds it high until its done pulse.
REQ-006 msg0, msg1, msg2  input  64 each  message payload, left-aligned; first byte sent is [63:56].
REQ-007 len0, len1, len2  input  4 each  message byte count; legal range 1..8.
REQ-008 fifo_full  input  1  TX FIFO full flag.
REQ-009 fifo_din  output  8  byte written to the TX FIFO.
REQ-010 fifo_wr_en  output  1  TX FIFO write strobe.
REQ-011 gnt  output  3  one-hot, one-cycle grant pulse.
REQ-012 done  output  3  one-hot, one-cycle completion pulse.
REQ-013 err_len  output  1  one-cycle pulse on an illegal length.
REQ-014 busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 All outputs are registered; there is no combinational path from any input to any output.
REQ-016 The state machine has three states: IDLE, SEND, DONE.
REQ-017 In IDLE with req!=0, the block selects a winner, latches that requester's msg and len into internal registers, pulses gnt for the winner, and clears the byte counter cnt to 0, all in the same cycle.
  - len in 1..8 -> next state SEND.
  - len 0 or len>8 -> err_len and done for the winner pulse on the following cycle; state stays IDLE; no FIFO write occurs.
REQ-018 Round-robin selection (PRIO_MODE=0) searches upward from the index after the last granted index, wrapping 2->0; the pointer resets to 2, so index 0 wins first.
REQ-019 Fixed-priority selection (PRIO_MODE=1) picks the lowest set index of req.
REQ-020 In SEND, on each cycle with fifo_full=0:
  - fifo_wr_en=1 and fifo_din = latched byte cnt (cnt=0 -> [63:56], cnt=7 -> [7:0]);
  - cnt increments by 1.
REQ-021 In SEND, on a cycle with fifo_full=1: fifo_wr_en=0, cnt holds, and no byte is skipped or duplicated.
REQ-022 When the byte with cnt==len-1 is written, next state is DONE.
REQ-023 In DONE, done pulses for the owner, the round-robin pointer updates to the owner index, and next state is IDLE; a new grant can occur on the cycle after DONE.
REQ-024 fifo_wr_en=0 and fifo_din=8'h00 in every state other than a writing SEND cycle.
REQ-025 req deasserting mid-message is ignored; the latched message completes.
REQ-026 Changes on msg*/len* after the grant do not affect the message in flight.
REQ-027 Simultaneous requests are served strictly one message at a time; bytes of different messages never interleave.
REQ-028 A requester that keeps req high after its done pulse is treated as a new request.

Reset
REQ-029 While rst=0, the block is held in this state:
  - state=IDLE, cnt=0, round-robin pointer=2, latched message/length=0;
  - gnt=0, done=0, err_len=0, fifo_wr_en=0, fifo_din=8'h00, busy=0.
REQ-030 Reset asserted mid-SEND aborts the message immediately: no further writes, and no done pulse after release.
REQ-031 After rst rises, the first grant can occur on the first active clock edge.

Verification
REQ-032 Single message: req=3'b001, msg0=64'h4552524F52210A00 ("ERROR!\n"), len0=7, fifo_full=0 -> gnt=001 pulse; 7 consecutive writes 45 52 52 4F 52 21 0A; done=001 pulse; busy low afterwards.
REQ-033 Round-robin contention: req=3'b111 held, each len=1 -> grant order 0,1,2,0; exactly one byte written per grant.
REQ-034 Fixed priority: PRIO_MODE=1, req=3'b110 -> requester 1 is served first, then 2; with req=3'b111, requester 0 wins every arbitration.
REQ-035 Backpressure: len=4, fifo_full=1 for 3 cycles after the 2nd byte -> exactly 4 writes in order; wr_en is low during the full cycles.
REQ-036 Illegal length: len1=0 and len2=9 requested -> err_len and done pulse for each; zero FIFO writes.
REQ-037 Reset mid-message: rst=0 after the 3rd byte of an 8-byte message -> all outputs reach reset values immediately; no done pulse; the next request after release is granted normally.
